// File: rtl/pulse_meas_pkg.sv
// Shared types and constants for the pulse width meter: FSM states, record layout, defaults.
package pulse_meas_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    MEAS     = 2'd2
  } meas_state_t;

  localparam int REC_W       = 4;
  localparam int DEF_MAX_LEN = 6;
  localparam int DEF_DEPTH   = 4;

  localparam int REC_ERR_POS = 3;
  localparam int REC_LEN_LSB = 0;
  localparam int REC_LEN_W   = 3;

  localparam logic [REC_LEN_W-1:0] CNT_MAX = 3'd7;

endpackage

// File: rtl/pulse_fifo.sv
// Show-ahead FIFO; dout reads as zero while empty so the head is well defined after reset.
module pulse_fifo
  import pulse_meas_pkg::*;
#(
  parameter int WIDTH = REC_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a concurrent push.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high-pulse widths on `in` and queues {err, len} records for a ready/valid consumer.
//   state    | meaning
//   WAIT_LOW | arming; a pulse already high at reset release is ignored
//   IDLE     | waiting for a pulse
//   MEAS     | counting a pulse
module pulse_width_meter
  import pulse_meas_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   in,
  output logic [REC_W-1:0]       len_data,
  output logic                   len_valid,
  input  logic                   len_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  meas_state_t          state;
  meas_state_t          state_next;
  logic [REC_LEN_W-1:0] cnt;
  logic [REC_LEN_W-1:0] cnt_next;
  logic                 push;
  logic [REC_W-1:0]     rec;
  logic                 pop;
  logic                 empty;
  logic                 full;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= WAIT_LOW;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      WAIT_LOW: if (!in) state_next = IDLE;
      IDLE: begin
        if (in) begin
          state_next = MEAS;
          cnt_next   = 3'd1;
        end
      end
      MEAS: begin
        if (in) begin
          cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 3'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = WAIT_LOW;
    endcase
  end

  always_comb begin
    push = 1'b0;
    rec  = '0;
    if (state == MEAS && !in) begin
      push = 1'b1;
      rec[REC_ERR_POS] = (int'(cnt) > MAX_LEN);
      rec[REC_LEN_LSB +: REC_LEN_W] = cnt;
    end
  end

  assign len_valid = !empty;
  assign pop       = len_valid && len_ready;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  pulse_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (push),
    .pop   (pop),
    .din   (rec),
    .dout  (len_data),
    .empty (empty),
    .full  (full),
    .level (level)
  );

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scenario bench for pulse_width_meter: expected records queued at stimulus time, popped records compared in order.
module tb_pulse_width_meter;

  logic       clk;
  logic       rst_;
  logic       in_s;
  logic [3:0] len_data;
  logic       len_valid;
  logic       len_ready;
  logic [2:0] level;
  logic       overflow;

  int n_cmp;
  int n_bad;
  int valid_cycles;
  bit rand_ready;
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  pulse_width_meter #(.MAX_LEN(6), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .in        (in_s),
    .len_data  (len_data),
    .len_valid (len_valid),
    .len_ready (len_ready),
    .level     (level),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Popped records are captured mid-cycle; the pop itself happens on the following rising edge.
  always @(negedge clk) begin
    if (rst_) begin
      if (len_valid) valid_cycles++;
      if (len_valid && len_ready) obs_q.push_back(len_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) len_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  function automatic logic [3:0] model_rec(input int len);
    int sat;
    sat = (len > 7) ? 7 : len;
    return {(sat > 6) ? 1'b1 : 1'b0, 3'(sat)};
  endfunction

  // High for n sampled edges, then one low edge that pushes the record.
  task automatic pulse(input int n);
    in_s = 1'b1;
    tick(n);
    in_s = 1'b0;
    tick(1);
  endtask

  task automatic do_reset(input logic in_val);
    rst_ = 1'b0;
    in_s = in_val;
    len_ready = 1'b0;
    rand_ready = 1'b0;
    tick(2);
    rst_ = 1'b1;
    exp_q.delete();
    obs_q.delete();
    valid_cycles = 0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    n_cmp++;
    if (level !== 3'd0) begin n_bad++; $display("FAIL reset_level got=%0d want=0", level); end
    n_cmp++;
    if (len_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", len_valid); end
    n_cmp++;
    if (len_data !== 4'd0) begin n_bad++; $display("FAIL reset_data got=%h want=0", len_data); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
  endtask

  task automatic test_basic;
    logic [3:0] e, o;
    do_reset(1'b0);
    tick(1);
    len_ready = 1'b1;
    pulse(5); exp_q.push_back(model_rec(5));
    pulse(9); exp_q.push_back(model_rec(9));
    tick(4);
    n_cmp++;
    if (valid_cycles !== 2) begin n_bad++; $display("FAIL basic_valid_cycles got=%0d want=2", valid_cycles); end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL basic_rec got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_high_at_reset;
    logic [3:0] e, o;
    do_reset(1'b1);
    len_ready = 1'b1;
    tick(3);
    in_s = 1'b0;
    tick(1);
    pulse(3); exp_q.push_back(model_rec(3));
    tick(3);
    n_cmp++;
    if (obs_q.size() !== 1) begin n_bad++; $display("FAIL arm_count got=%0d want=1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL arm_rec got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_overflow;
    logic [3:0] e, o;
    do_reset(1'b0);
    tick(1);
    for (int i = 0; i < 6; i++) begin
      pulse(2);
      if (i < 4) exp_q.push_back(model_rec(2));
    end
    n_cmp++;
    if (level !== 3'd4) begin n_bad++; $display("FAIL ovf_level got=%0d want=4", level); end
    n_cmp++;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    len_ready = 1'b1;
    tick(6);
    n_cmp++;
    if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    n_cmp++;
    if (obs_q.size() !== 4) begin n_bad++; $display("FAIL ovf_count got=%0d want=4", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL ovf_rec got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_full_push_pop;
    logic [3:0] e, o;
    do_reset(1'b0);
    tick(1);
    for (int i = 1; i <= 4; i++) begin
      pulse(i);
      exp_q.push_back(model_rec(i));
    end
    n_cmp++;
    if (level !== 3'd4) begin n_bad++; $display("FAIL fpp_fill got=%0d want=4", level); end
    in_s = 1'b1;
    tick(5);
    in_s = 1'b0;
    len_ready = 1'b1;
    tick(1);
    len_ready = 1'b0;
    exp_q.push_back(model_rec(5));
    n_cmp++;
    if (level !== 3'd4) begin n_bad++; $display("FAIL fpp_level got=%0d want=4", level); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_overflow got=%b want=0", overflow); end
    len_ready = 1'b1;
    tick(7);
    n_cmp++;
    if (obs_q.size() !== 5) begin n_bad++; $display("FAIL fpp_count got=%0d want=5", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL fpp_rec got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b0);
    tick(1);
    pulse(2);
    pulse(3);
    n_cmp++;
    if (level !== 3'd2) begin n_bad++; $display("FAIL rmid_queued got=%0d want=2", level); end
    in_s = 1'b1;
    tick(2);
    rst_ = 1'b0;
    tick(1);
    rst_ = 1'b1;
    n_cmp++;
    if (level !== 3'd0) begin n_bad++; $display("FAIL rmid_level got=%0d want=0", level); end
    n_cmp++;
    if (len_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got=%b want=0", len_valid); end
    tick(1);
    in_s = 1'b0;
    len_ready = 1'b1;
    tick(4);
    n_cmp++;
    if (obs_q.size() !== 0 || len_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_no_record got=%0d want=0", obs_q.size());
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] e, o;
    int len;
    do_reset(1'b0);
    tick(1);
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      len = $urandom_range(1, 9);
      pulse(len);
      exp_q.push_back(model_rec(len));
      tick(2);
    end
    rand_ready = 1'b0;
    len_ready = 1'b1;
    tick(8);
    n_cmp++;
    if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_overflow got=%b want=0", overflow); end
    n_cmp++;
    if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b_rec got=%h want=%h", o, e); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    valid_cycles = 0;
    rand_ready = 1'b0;
    rst_ = 1'b0;
    in_s = 1'b0;
    len_ready = 1'b0;
    test_reset();
    test_basic();
    test_high_at_reset();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_width_meter.md
PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with the clock and reset ports named clk and rst_.
REQ-002 Parameter MAX_LEN SHALL default to 6 and is the longest legal pulse width, in cycles.
REQ-003 Parameter DEPTH SHALL default to 4 and is the number of FIFO entries, a power of two of at least 2.
REQ-004 clk SHALL be an input, 1 bit wide: the rising-edge clock.
REQ-005 rst_ SHALL be an input, 1 bit wide: the synchronous active-low reset.
REQ-006 in SHALL be an input, 1 bit wide: the pulse stream, driven by the out port of the upstream pulse-length stage.
REQ-007 len_data SHALL be an output, 4 bits wide: record {err, len[2:0]} at the FIFO head.
REQ-008 len_valid SHALL be an output, 1 bit wide: high while the FIFO is non-empty.
REQ-009 len_ready SHALL be an input, 1 bit wide: consumer accept; a pop occurs when len_valid and len_ready are both high.
REQ-010 level SHALL be an output, $clog2(DEPTH)+1 bits wide: current FIFO occupancy.
REQ-011 overflow SHALL be an output, 1 bit wide: sticky flag meaning a record was dropped.

Function
REQ-012 The measurement FSM SHALL have exactly three states:
- WAIT_LOW: arming.
- IDLE: waiting for a pulse.
- MEAS: counting a pulse.
REQ-013 WAIT_LOW SHALL go to IDLE on the first edge that samples in=0; otherwise it SHALL stay in WAIT_LOW, so a pulse already high at reset release is never measured.
REQ-014 IDLE SHALL go to MEAS with cnt=1 on an edge that samples in=1; otherwise it SHALL stay in IDLE.
REQ-015 MEAS SHALL increment cnt on each edge that samples in=1, saturating at 7 (3-bit counter, no wrap).
REQ-016 On the first edge in MEAS that samples in=0, MEAS SHALL push the record and return to IDLE.
- Record fields: len=cnt; err=1 if cnt>MAX_LEN.
REQ-017 The record SHALL be visible at the FIFO head one cycle after that edge, or later if older entries are queued.
REQ-018 A low of one sample between pulses SHALL be sufficient: IDLE accepts in=1 on the very next edge.
REQ-019 The FIFO SHALL be show-ahead: len_data is valid whenever len_valid=1, and len_data SHALL be held stable until popped.
REQ-020 A push with the FIFO full and no pop SHALL drop the record, leave FIFO contents unchanged, and set overflow.
REQ-021 A push with the FIFO full and a simultaneous pop SHALL be accepted, and level SHALL remain DEPTH.
REQ-022 A simultaneous push and pop when the FIFO is not full SHALL leave level unchanged.
REQ-023 With the FIFO empty, a push SHALL NOT be poppable in the same cycle, because len_valid is low.
REQ-024 len_ready while len_valid=0 SHALL have no effect.
REQ-025 overflow SHALL clear only on reset.
REQ-026 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH.

Reset
REQ-027 While rst_=0 at a clock edge, the block SHALL enter WAIT_LOW, with cnt=0, both pointers=0, level=0, len_valid=0, len_data=0 and overflow=0.
REQ-028 A reset during MEAS SHALL discard the partial measurement without pushing it.
REQ-029 A reset SHALL discard all queued records.

Structure
REQ-030 Package pulse_meas_pkg SHALL hold:
- the FSM state enum (WAIT_LOW, IDLE, MEAS);
- the record width constant (4);
- the default MAX_LEN and DEPTH constants;
- the record field positions.
REQ-031 Storage SHALL be one sub-module, pulse_fifo, parameterised by width and DEPTH, with ports push, pop, din, dout, empty, full and level.
REQ-032 The FSM and counter SHALL reside in pulse_width_meter.

Verification
REQ-033 After reset release with in=0, a pulse of in high for 5 cycles followed by low, with len_ready=1, SHALL produce one record {0,5} with len_valid high for exactly 1 cycle.
REQ-034 A pulse of 9 cycles SHALL produce record {1,7}: err set and length saturated at 7.
REQ-035 With in high before and through reset release, then falling low and pulsing 3 cycles, the bench SHALL see exactly one record, {0,3}.
REQ-036 Six pulses of 2 cycles, separated by 1-cycle lows, with len_ready=0 and DEPTH=4, SHALL give:
- level=4 and overflow=1;
- after draining: records {0,2} x4, with the 5th and 6th dropped.
REQ-037 A push coinciding with a pop while level=4 SHALL leave level=4 and overflow=0, and the new record SHALL emerge last in order.
REQ-038 Asserting rst_=0 for 1 cycle in the middle of a 4-cycle pulse, with 2 records queued, SHALL give level=0, len_valid=0, and no record from the interrupted pulse.
